// File: rtl/adsr_envelope.sv
// adsr_envelope: gate-driven attack/decay/sustain/release amplitude envelope
// applied to a 16-bit unsigned oscillator wave. The envelope level moves once
// per control tick (every TICK_DIV clocks). Gate edges change state on any
// clock. The output is offset-binary (0x8000 = silence) after a 2-stage
// multiply pipeline.
module adsr_envelope #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned TICK_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gate,
  input  logic [15:0] attack_step,
  input  logic [15:0] decay_step,
  input  logic [15:0] sustain_level,
  input  logic [15:0] release_step,
  input  logic [15:0] wave_in,
  output logic [15:0] wave_out,
  output logic [15:0] envelope,
  output logic        active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_e;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_e            state_q, state_d;
  logic [15:0]       env_q, env_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic              gate_q;
  logic              tick, rise, fall;

  // Level arithmetic is done 17 bits wide so that overflow and underflow are visible.
  logic [16:0]       att_sum, dec_lim;
  logic [15:0]       att_sat, rel_sub;

  logic signed [15:0] wave_s;
  logic signed [16:0] env_s;
  logic [15:0]        p1_q, p1_d;
  logic [15:0]        out_q, out_d;

  // Tick divider, gate edge detect and level arithmetic for the current cycle.
  always_comb begin
    tick    = (cnt_q == TICK_LAST);
    cnt_d   = tick ? '0 : cnt_q + TICK_W'(1);
    rise    = gate & ~gate_q;
    fall    = ~gate & gate_q;
    att_sum = {1'b0, env_q} + {1'b0, attack_step};
    att_sat = att_sum[16] ? 16'hFFFF : att_sum[15:0];
    dec_lim = {1'b0, sustain_level} + {1'b0, decay_step};
    rel_sub = (env_q > release_step) ? (env_q - release_step) : 16'h0000;
  end

  // Next-state and next-level logic. A gate edge takes priority over a tick in the same cycle.
  always_comb begin
    // NOTE: every variable gets a hold value first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    env_d   = env_q;
    case (state_q)
      S_IDLE: begin
        env_d = 16'h0000;
        if (rise) state_d = S_ATTACK;
      end
      S_ATTACK: begin
        if (fall) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          env_d = att_sat;
          if (att_sat == 16'hFFFF) state_d = S_DECAY;
        end
      end
      S_DECAY: begin
        if (fall) begin
          state_d = S_RELEASE;
        end else if (tick) begin
          if ({1'b0, env_q} <= dec_lim) begin
            env_d   = sustain_level;
            state_d = S_SUSTAIN;
          end else begin
            env_d = env_q - decay_step;
          end
        end
      end
      S_SUSTAIN: begin
        // A gate fall holds the level as it is. Otherwise the level follows
        // sustain_level live.
        if (fall) state_d = S_RELEASE;
        else      env_d   = sustain_level;
      end
      S_RELEASE: begin
        if (rise) begin
          state_d = S_ATTACK;
        end else if (tick) begin
          env_d = rel_sub;
          if (rel_sub == 16'h0000) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        env_d   = 16'h0000;
      end
    endcase
  end

  // State, level, tick counter and gate history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      env_q   <= 16'h0000;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      env_q   <= env_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate;
    end
  end

  // Output scaling. Stage 1 forms the signed product and keeps only its >>16
  // part. Stage 2 adds the offset back.
  always_comb begin
    wave_s = signed'(wave_in ^ 16'h8000);
    env_s  = signed'({1'b0, env_q});
    p1_d   = 16'((33'(wave_s) * 33'(env_s)) >>> 16);
    out_d  = p1_q ^ 16'h8000;
  end

  // Pipeline registers. They run every clock, whatever the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_q  <= 16'h0000;
      out_q <= 16'h8000;
    end else begin
      p1_q  <= p1_d;
      out_q <= out_d;
    end
  end

  assign wave_out = out_q;
  assign envelope = env_q;
  assign active   = (state_q != S_IDLE);

endmodule
